vout_sine3_ctrl: RTL

- Three-phase sine-PWM sequencer for stepper and BLDC drives.
- Converts a signed step-period command into a ramped phase index and drives three 120°-offset sine-PWM outputs from one shared PWM carrier.
- Adds acceleration limiting, safe direction reversal via stop, and amplitude scaling.
- Sits between the LinuxCNC-RIO register interface (freq, enable, amplitude) and the motor driver pins.

---
 rtl/vout_sine3_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vout_sine3_ctrl.sv
// vout_sine3_ctrl - three-phase sine-PWM sequencer for stepper/BLDC drives.
//
// A signed step-period command is turned into a ramped phase index. That
// index drives three sine-PWM outputs, offset by 120 degrees, which share
// one PWM carrier. The controller limits acceleration, reverses direction
// only by stopping first, and scales the output amplitude.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     run permission; low forces a ramp down to stop
//   freq       signed target step period (|freq| = clocks per table step,
//              sign = direction, 0 = stop)
//   amplitude  duty scale (255 ~ full table swing, 0 = all phases at 128)
//   pwm_u/v/w  phase PWM outputs
//   running    high in ACCEL, RUN and DECEL
//   dir        latched direction, 1 = forward (index incrementing)
//   idx        current phase-U table index, 0..29
//
// Optional build macro: VOUT_SINE3_CTRL_HOLD_EN
//   When defined, the outputs keep PWMing the duties of the frozen index
//   while IDLE, which gives holding torque. When undefined, the outputs
//   are low in IDLE.

module vout_sine3_ctrl #(
  parameter int unsigned DIVIDER      = 255,
  parameter int unsigned START_PERIOD = 5000,
  parameter int unsigned MIN_PERIOD   = 16,
  parameter int unsigned RAMP_DIV     = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [31:0] freq,
  input  logic        [7:0]  amplitude,
  output logic               pwm_u,
  output logic               pwm_v,
  output logic               pwm_w,
  output logic               running,
  output logic               dir,
  output logic        [4:0]  idx
);

  localparam logic [31:0] DIV_P   = 32'(DIVIDER);
  localparam logic [31:0] START_P = 32'(START_PERIOD);
  localparam logic [31:0] MIN_P   = 32'(MIN_PERIOD);
  localparam logic [31:0] RAMP_P  = 32'(RAMP_DIV);

  typedef enum logic [1:0] {IDLE, ACCEL, RUN, DECEL} state_t;

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] cur_period_q, cur_period_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic [31:0] ramp_cnt_q, ramp_cnt_d;
  logic [31:0] carrier_q, carrier_d;
  logic [7:0]  duty_u_q, duty_u_d, duty_v_q, duty_v_d, duty_w_q, duty_w_d;
  logic [7:0]  lat_u_q, lat_u_d, lat_v_q, lat_v_d, lat_w_q, lat_w_d;
  logic        out_en_lat_q, out_en_lat_d;

  logic [31:0] tmag_raw, tmag, target, cur_toward;
  logic        tdir, want, ramp_tick, carrier_wrap, out_en;

  function automatic logic [7:0] sine_lut(input logic [4:0] i);
    logic [7:0] v;
    case (i)
      5'd0:  v = 8'd128;  5'd1:  v = 8'd153;  5'd2:  v = 8'd177;
      5'd3:  v = 8'd199;  5'd4:  v = 8'd217;  5'd5:  v = 8'd232;
      5'd6:  v = 8'd242;  5'd7:  v = 8'd247;  5'd8:  v = 8'd247;
      5'd9:  v = 8'd242;  5'd10: v = 8'd232;  5'd11: v = 8'd217;
      5'd12: v = 8'd199;  5'd13: v = 8'd177;  5'd14: v = 8'd153;
      5'd15: v = 8'd128;  5'd16: v = 8'd103;  5'd17: v = 8'd79;
      5'd18: v = 8'd57;   5'd19: v = 8'd39;   5'd20: v = 8'd24;
      5'd21: v = 8'd14;   5'd22: v = 8'd9;    5'd23: v = 8'd9;
      5'd24: v = 8'd14;   5'd25: v = 8'd24;   5'd26: v = 8'd39;
      5'd27: v = 8'd57;   5'd28: v = 8'd79;   5'd29: v = 8'd103;
      default: v = 8'd128;
    endcase
    return v;
  endfunction

  // (i + off) mod 30 for i in 0..29 and off in {10, 20}
  function automatic logic [4:0] wrap30(input logic [4:0] i, input logic [4:0] off);
    logic [5:0] s;
    s = {1'b0, i} + {1'b0, off};
    return (s >= 6'd30) ? 5'(s - 6'd30) : s[4:0];
  endfunction

  // 128 + ((t - 128) * amp) >>> 8 with 17-bit signed intermediates
  function automatic logic [7:0] scale(input logic [7:0] t, input logic [7:0] amp);
    logic signed [16:0] diff, prod, sh;
    diff = $signed({9'd0, t}) - 17'sd128;
    prod = diff * $signed({9'd0, amp});
    sh   = prod >>> 8;
    return 8'(sh + 17'sd128);
  endfunction

  // Decode the command: magnitude clamped to MIN_PERIOD, direction, and
  // the effective target which never exceeds the start period.
  always_comb begin
    tmag_raw = freq[31] ? (32'd0 - $unsigned(freq)) : $unsigned(freq);
    tmag     = ((tmag_raw != 32'd0) && (tmag_raw < MIN_P)) ? MIN_P : tmag_raw;
    target   = (tmag < START_P) ? tmag : START_P;
    tdir     = !freq[31] && (freq != 32'sd0);
    want     = enable && (freq != 32'sd0);
  end

  assign ramp_tick = (ramp_cnt_q == RAMP_P - 32'd1);

  // Sequencer: phase stepping while moving, plus the ramp/direction FSM.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    idx_d        = idx_q;
    cur_period_d = cur_period_q;
    step_cnt_d   = step_cnt_q;
    ramp_cnt_d   = ramp_cnt_q;
    cur_toward   = cur_period_q;

    if (cur_period_q > target) begin
      cur_toward = cur_period_q - 32'd1;
    end else if (cur_period_q < target) begin
      cur_toward = cur_period_q + 32'd1;
    end

    if (state_q != IDLE) begin
      ramp_cnt_d = ramp_tick ? 32'd0 : ramp_cnt_q + 32'd1;
      // ">=" rather than "==" so a period cut below the current count
      // yields one step next clock instead of a counter run-away.
      if (step_cnt_q >= cur_period_q - 32'd1) begin
        step_cnt_d = 32'd0;
        if (dir_q) begin
          idx_d = (idx_q == 5'd29) ? 5'd0 : idx_q + 5'd1;
        end else begin
          idx_d = (idx_q == 5'd0) ? 5'd29 : idx_q - 5'd1;
        end
      end else begin
        step_cnt_d = step_cnt_q + 32'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (want) begin
          state_d      = ACCEL;
          dir_d        = tdir;
          cur_period_d = START_P;
          step_cnt_d   = 32'd0;
          ramp_cnt_d   = 32'd0;
        end
      end
      ACCEL: begin
        if (!want || (tdir != dir_q)) begin
          state_d = DECEL;
        end else if (ramp_tick) begin
          cur_period_d = cur_toward;
          if (cur_toward == target) state_d = RUN;
        end
      end
      RUN: begin
        if (!want || (tdir != dir_q)) begin
          state_d = DECEL;
        end else if (ramp_tick && (cur_period_q != target)) begin
          state_d = ACCEL;
        end
      end
      DECEL: begin
        // A returning command in the same direction resumes without a stop;
        // a direction change must ride down to IDLE first.
        if (want && (tdir == dir_q)) begin
          state_d = ACCEL;
        end else if (ramp_tick) begin
          if (cur_period_q + 32'd1 >= START_P) begin
            cur_period_d = START_P;
            state_d      = IDLE;
          end else begin
            cur_period_d = cur_period_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef VOUT_SINE3_CTRL_HOLD_EN
  assign out_en = 1'b1;
`else
  assign out_en = (state_q != IDLE);
`endif

  // Duty pipeline and carrier. Duties and the output enable are only taken
  // on the carrier wrap so a PWM period never changes shape mid-way.
  always_comb begin
    duty_u_d     = scale(sine_lut(idx_q), amplitude);
    duty_v_d     = scale(sine_lut(wrap30(idx_q, 5'd10)), amplitude);
    duty_w_d     = scale(sine_lut(wrap30(idx_q, 5'd20)), amplitude);
    carrier_wrap = (carrier_q == DIV_P - 32'd1);
    carrier_d    = carrier_wrap ? 32'd0 : carrier_q + 32'd1;
    lat_u_d      = carrier_wrap ? duty_u_q : lat_u_q;
    lat_v_d      = carrier_wrap ? duty_v_q : lat_v_q;
    lat_w_d      = carrier_wrap ? duty_w_q : lat_w_q;
    out_en_lat_d = carrier_wrap ? out_en : out_en_lat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      idx_q        <= 5'd0;
      cur_period_q <= START_P;
      step_cnt_q   <= 32'd0;
      ramp_cnt_q   <= 32'd0;
      carrier_q    <= 32'd0;
      duty_u_q     <= 8'd0;
      duty_v_q     <= 8'd0;
      duty_w_q     <= 8'd0;
      lat_u_q      <= 8'd0;
      lat_v_q      <= 8'd0;
      lat_w_q      <= 8'd0;
      out_en_lat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      idx_q        <= idx_d;
      cur_period_q <= cur_period_d;
      step_cnt_q   <= step_cnt_d;
      ramp_cnt_q   <= ramp_cnt_d;
      carrier_q    <= carrier_d;
      duty_u_q     <= duty_u_d;
      duty_v_q     <= duty_v_d;
      duty_w_q     <= duty_w_d;
      lat_u_q      <= lat_u_d;
      lat_v_q      <= lat_v_d;
      lat_w_q      <= lat_w_d;
      out_en_lat_q <= out_en_lat_d;
    end
  end

  assign pwm_u   = out_en_lat_q && (carrier_q < {24'd0, lat_u_q});
  assign pwm_v   = out_en_lat_q && (carrier_q < {24'd0, lat_v_q});
  assign pwm_w   = out_en_lat_q && (carrier_q < {24'd0, lat_w_q});
  assign running = (state_q != IDLE);
  assign dir     = dir_q;
  assign idx     = idx_q;

endmodule
